// File: rtl/ram_word_loader.sv
// Framed byte-stream loader for the LED-pattern word RAM.
// Assembles little-endian words and writes them at consecutive addresses.
module ram_word_loader #(
    parameter int         ADDR_W      = 10,
    parameter int         BASE_ADDR   = 0,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_wr
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_LEN = 17'((2 ** ADDR_W) - BASE_ADDR);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          code_q, code_d;
    logic [ADDR_W:0]     words_q, words_d;

    logic accept;
    logic active;
    logic tmo_hit;

    assign in_ready = !rst && (state_q != S_DONE) && (state_q != S_ERR);
    assign accept   = in_valid && in_ready;
    assign active   = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
    assign tmo_hit  = active && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        code_d  = code_q;
        words_d = words_q;
        tmo_d   = (accept || !active) ? '0 : tmo_q + TW'(1);

        // Timeout wins over a byte arriving in the same cycle
        if (tmo_hit) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'b11;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state_d = S_LEN_LO;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        code_d  = 2'b00;
                        words_d = '0;
                        sum_d   = '0;
                        bcnt_d  = '0;
                        word_d  = '0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_d[7:0] = in_data;
                        state_d    = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = in_data;
                        if (len_d == 16'd0) begin
                            state_d = S_CSUM;
                        end else if ({1'b0, len_d} > MAX_LEN) begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                            code_d  = 2'b01;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sum_d                = sum_q + in_data;
                        bcnt_d               = bcnt_q + 2'd1;
                        word_d[8*bcnt_q +: 8] = in_data;
                        if (bcnt_q == 2'd3) begin
                            we_d    = 1'b1;
                            addr_d  = ADDR_W'(BASE_ADDR)
                                    + words_q[ADDR_W-1:0];
                            wdata_d = word_d;
                            words_d = words_q + (ADDR_W+1)'(1);
                            if (17'(words_q) + 17'd1 == {1'b0, len_q})
                                state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                            code_d  = 2'b10;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
            words_q <= words_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = code_q;
    assign words_wr  = words_q;

endmodule

// File: tb/tb_ram_word_loader.sv
// Bench for ram_word_loader: frame-position reference model,
// per-cycle output compare, directed and randomized frames.
module tb_ram_word_loader;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [10:0] words_wr;

    int n_chk  = 0;
    int n_fail = 0;

    ram_word_loader #(
        .ADDR_W(10), .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .words_wr(words_wr)
    );

    always #5 clk = ~clk;

    // Reference model: position of the byte within the frame
    bit          m_started = 1'b0;
    int          m_pos = -1;
    int          m_len = 0;
    int          m_sum = 0;
    int          m_idle = 0;
    bit          m_flash = 1'b0;
    logic [31:0] m_acc = '0;
    bit          e_we = 0;
    int          e_addr = 0;
    logic [31:0] e_wdata = '0;
    bit          e_busy = 0;
    bit          e_done = 0;
    bit          e_err = 0;
    int          e_code = 0;
    int          e_words = 0;

    always @(posedge clk) begin
        bit acc;
        int k;
        acc = in_valid && !rst && !m_flash;
        m_started = 1'b1;
        e_we = 0;
        if (rst) begin
            m_pos = -1; m_flash = 0; m_idle = 0; m_sum = 0; m_acc = '0;
            e_addr = 0; e_wdata = '0; e_busy = 0; e_done = 0;
            e_err = 0; e_code = 0; e_words = 0;
        end else if (m_flash) begin
            m_flash = 0;
            e_busy = 0;
        end else if (m_pos < 0) begin
            if (acc && in_data == 8'hA5) begin
                m_pos = 0; e_done = 0; e_err = 0; e_code = 0;
                e_words = 0; m_sum = 0; m_idle = 0; m_acc = '0;
                e_busy = 1;
            end
        end else if (m_idle == T - 1) begin
            e_err = 1; e_code = 3; m_pos = -1; m_flash = 1;
        end else if (!acc) begin
            m_idle++;
        end else begin
            m_idle = 0;
            if (m_pos == 0) begin
                m_len = int'(in_data);
                m_pos++;
            end else if (m_pos == 1) begin
                m_len += 256 * int'(in_data);
                if (m_len > 1024) begin
                    e_err = 1; e_code = 1; m_pos = -1; m_flash = 1;
                end else begin
                    m_pos++;
                end
            end else if (m_pos < 2 + 4 * m_len) begin
                k = m_pos - 2;
                m_sum = (m_sum + int'(in_data)) % 256;
                m_acc = m_acc | (32'(in_data) << (8 * (k % 4)));
                if (k % 4 == 3) begin
                    e_we = 1; e_addr = k / 4; e_wdata = m_acc;
                    m_acc = '0; e_words = k / 4 + 1;
                end
                m_pos++;
            end else begin
                if (int'(in_data) == m_sum) e_done = 1;
                else begin e_err = 1; e_code = 2; end
                m_pos = -1; m_flash = 1;
            end
        end
    end

    logic [9:0]  la[$];
    logic [31:0] ld[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("error", 32'(error), 32'(e_err));
                chk("err_code", 32'(err_code), 32'(e_code));
                chk("words_wr", 32'(words_wr), 32'(e_words));
                chk("in_ready", 32'(in_ready), 32'(!rst && !m_flash));
                if (mem_we) begin
                    la.push_back(mem_addr);
                    ld.push_back(mem_wdata);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        tick();
        while (!in_ready && n < 8) begin
            in_valid = 1'b0;
            tick();
            n++;
        end
        chk("ready_wait", 32'(n < 8), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic rst_pulse();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] cs);
        logic [7:0] f[12];
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, cs};
        foreach (f[i]) send(f[i]);
    endtask

    task automatic check_frame1(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(la.size() - base), 32'd2);
        if (la.size() >= base + 2) begin
            chk({tag, "_a0"}, 32'(la[base]), 32'd0);
            chk({tag, "_d0"}, ld[base], 32'h44332211);
            chk({tag, "_a1"}, 32'(la[base+1]), 32'd1);
            chk({tag, "_d1"}, ld[base+1], 32'h88776655);
        end
    endtask

    task automatic rand_frame();
        int kind, len, stop, cnt;
        logic [7:0] b, s;
        kind = $urandom_range(0, 9);
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b);
        end
        len = (kind == 0) ? 1025 + $urandom_range(0, 3)
                          : $urandom_range(0, 5);
        stop = $urandom_range(1, 2 + 4 * len);
        send(8'hA5);
        send(8'(len));
        send(8'(len >> 8));
        if (kind == 0) begin
            idle(2);
            return;
        end
        s = 8'h00;
        cnt = 0;
        for (int i = 0; i < 4 * len; i++) begin
            if ((kind == 2 || kind == 3) && cnt == stop) break;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            b = 8'($urandom);
            s = s + b;
            send(b);
            cnt++;
        end
        if (kind == 2 && cnt == stop) begin
            idle(T + 2);
            return;
        end
        if (kind == 3 && cnt == stop) begin
            rst_pulse();
            return;
        end
        send((kind == 1) ? s + 8'h01 : s);
        idle($urandom_range(1, 3));
    endtask

    initial begin
        int base;
        fork
            compare_loop();
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none

        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);

        base = la.size();
        send_frame1(8'h64);
        idle(3);
        check_frame1("t1", base);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(error), 32'd0);
        chk("t1_words", 32'(words_wr), 32'd2);

        base = la.size();
        send_frame1(8'h65);
        idle(3);
        check_frame1("t2", base);
        chk("t2_err", 32'(error), 32'd1);
        chk("t2_code", 32'(err_code), 32'd2);
        chk("t2_done", 32'(done), 32'd0);

        base = la.size();
        send(8'hA5); send(8'h01); send(8'h04);
        idle(3);
        chk("t3_err", 32'(error), 32'd1);
        chk("t3_code", 32'(err_code), 32'd1);
        chk("t3_nwr", 32'(la.size() - base), 32'd0);

        base = la.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        idle(T + 2);
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_code", 32'(err_code), 32'd3);
        chk("t4_nwr", 32'(la.size() - base), 32'd0);
        send(8'hA5);
        idle(1);
        chk("t4_clr", 32'(error), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        idle(T + 2);

        send(8'h00); send(8'hFF); send(8'h3C);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_words", 32'(words_wr), 32'd0);

        base = la.size();
        send(8'hA5); send(8'h03); send(8'h00);
        for (int i = 1; i <= 6; i++) send(8'(i));
        rst_pulse();
        chk("t6_nwr", 32'(la.size() - base), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_words", 32'(words_wr), 32'd0);
        chk("t6_we", 32'(mem_we), 32'd0);
        base = la.size();
        send_frame1(8'h64);
        idle(3);
        check_frame1("t6b", base);

        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02);
        idle(T - 2);
        send(8'h03); send(8'h04); send(8'h0A);
        idle(3);
        chk("gap_ok_done", 32'(done), 32'd1);

        send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        idle(T - 1);
        send(8'h02);
        idle(3);
        chk("gap_late_err", 32'(error), 32'd1);
        chk("gap_late_code", 32'(err_code), 32'd3);

        repeat (80) rand_frame();
        idle(T + 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
